local_port_ni: RTL and testbench

Network interface for a router's Local port (port index 4).
- Send path: takes words from the tile through a valid/ready interface and drives them into the router's Local input channel with a four-phase req/ack handshake.
- Receive path: accepts words from the router's Local output channel with the same handshake and buffers them in a small FIFO for the tile.
- Counts words sent and received, for end-of-run traffic checks.

---
 rtl/local_port_ni_pkg.sv | 13 +
 rtl/local_port_ni_rx_buffer.sv | 54 +++++
 rtl/local_port_ni.sv | 126 ++++++++++++
 tb/tb_local_port_ni.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/local_port_ni_pkg.sv
// Shared constants and send FSM state encoding for the Local-port network interface.
package local_port_ni_pkg;

  localparam int SIZE     = 16;
  localparam int NI_CNT_W = 16;

  typedef enum logic [1:0] {
    NI_S_IDLE = 2'd0,
    NI_S_REQ  = 2'd1,
    NI_S_RTZ  = 2'd2
  } ni_send_state_e;

endpackage

// File: rtl/local_port_ni_rx_buffer.sv
// First-word-fall-through receive buffer; pointers carry one extra wrap bit
// so full and empty can be told apart when the index bits match.
module ni_rx_buffer
  import local_port_ni_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            write,
  input  logic [SIZE-1:0] item_in,
  input  logic            read,
  output logic [SIZE-1:0] item_out,
  output logic            full,
  output logic            empty
);

  localparam int AW = $clog2(DEPTH);

  logic [SIZE-1:0] mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            wr_en, rd_en;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_en    = write && !full;
  assign rd_en    = read && !empty;
  assign item_out = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= item_in;
  end

endmodule

// File: rtl/local_port_ni.sv
// Local-port network interface: valid/ready tile side, four-phase req/ack
// router side in both directions, plus traffic counters.
module local_port_ni
  import local_port_ni_pkg::*;
#(
  parameter int id    = -1,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                send_valid,
  output logic                send_ready,
  input  logic [SIZE-1:0]     send_data,
  output logic                recv_valid,
  input  logic                recv_ready,
  output logic [SIZE-1:0]     recv_data,
  output logic                tx_req,
  input  logic                tx_ack,
  output logic [SIZE-1:0]     tx_data,
  input  logic                rx_req,
  output logic                rx_ack,
  input  logic [SIZE-1:0]     rx_data,
  output logic [NI_CNT_W-1:0] sent_count,
  output logic [NI_CNT_W-1:0] recv_count
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("local_port_ni(id=%0d): DEPTH must be a power of two >= 2", id);
  end

  ni_send_state_e        state_q, state_d;
  logic                  tx_req_q;
  logic [SIZE-1:0]       tx_data_q;
  logic [NI_CNT_W-1:0]   sent_count_q;
  logic                  rx_ack_q, rx_ack_d;
  logic [NI_CNT_W-1:0]   recv_count_q;
  logic                  accept, ack_done;
  logic                  capture, pop;
  logic                  buf_full, buf_empty;

  // send_ready is also gated by tx_ack so a stale ack held high in idle
  // can never let a word be accepted that the FSM would not register.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    ack_done   = 1'b0;
    send_ready = 1'b0;
    case (state_q)
      NI_S_IDLE: begin
        send_ready = !tx_ack;
        if (send_valid && !tx_ack) begin
          state_d = NI_S_REQ;
          accept  = 1'b1;
        end
      end
      NI_S_REQ: begin
        if (tx_ack) begin
          state_d  = NI_S_RTZ;
          ack_done = 1'b1;
        end
      end
      NI_S_RTZ: begin
        if (!tx_ack) state_d = NI_S_IDLE;
      end
      default: state_d = NI_S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= NI_S_IDLE;
      tx_req_q     <= 1'b0;
      tx_data_q    <= '0;
      sent_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        tx_req_q  <= 1'b1;
        tx_data_q <= send_data;
      end
      if (ack_done) begin
        tx_req_q     <= 1'b0;
        sent_count_q <= sent_count_q + NI_CNT_W'(1);
      end
    end
  end

  // Full is the pre-edge state, so a same-edge pop never frees room for a capture.
  assign capture = rx_req && !rx_ack_q && !buf_full;
  assign pop     = recv_ready && !buf_empty;

  always_comb begin
    rx_ack_d = rx_ack_q;
    if (capture)      rx_ack_d = 1'b1;
    else if (!rx_req) rx_ack_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ack_q     <= 1'b0;
      recv_count_q <= '0;
    end else begin
      rx_ack_q <= rx_ack_d;
      if (capture) recv_count_q <= recv_count_q + NI_CNT_W'(1);
    end
  end

  ni_rx_buffer #(.DEPTH(DEPTH)) u_rx_buffer (
    .clk      (clk),
    .reset    (reset),
    .write    (capture),
    .item_in  (rx_data),
    .read     (pop),
    .item_out (recv_data),
    .full     (buf_full),
    .empty    (buf_empty)
  );

  assign recv_valid = !buf_empty;
  assign tx_req     = tx_req_q;
  assign tx_data    = tx_data_q;
  assign rx_ack     = rx_ack_q;
  assign sent_count = sent_count_q;
  assign recv_count = recv_count_q;

endmodule

// File: tb/tb_local_port_ni.sv
// Self-checking bench for local_port_ni: directed handshake scenarios plus a
// randomized two-way traffic run against queue scoreboards.
module tb_local_port_ni;
  import local_port_ni_pkg::*;

  localparam int DEPTH  = 4;
  localparam int NWORDS = 1000;

  logic                clk = 1'b0;
  logic                reset;
  logic                send_valid;
  logic                send_ready;
  logic [SIZE-1:0]     send_data;
  logic                recv_valid;
  logic                recv_ready;
  logic [SIZE-1:0]     recv_data;
  logic                tx_req;
  logic                tx_ack;
  logic [SIZE-1:0]     tx_data;
  logic                rx_req;
  logic                rx_ack;
  logic [SIZE-1:0]     rx_data;
  logic [NI_CNT_W-1:0] sent_count;
  logic [NI_CNT_W-1:0] recv_count;

  logic tx_ack_r;
  logic ack_comb;
  assign tx_ack = ack_comb ? tx_req : tx_ack_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  local_port_ni #(.id(4), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .send_valid (send_valid),
    .send_ready (send_ready),
    .send_data  (send_data),
    .recv_valid (recv_valid),
    .recv_ready (recv_ready),
    .recv_data  (recv_data),
    .tx_req     (tx_req),
    .tx_ack     (tx_ack),
    .tx_data    (tx_data),
    .rx_req     (rx_req),
    .rx_ack     (rx_ack),
    .rx_data    (rx_data),
    .sent_count (sent_count),
    .recv_count (recv_count)
  );

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    send_valid = 1'b0; send_data = '0; recv_ready = 1'b0;
    rx_req = 1'b0; rx_data = '0; tx_ack_r = 1'b0; ack_comb = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (send_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_send_ready: got %b expected 1", send_ready); end
    checks++; if (tx_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_req: got %b expected 0", tx_req); end
    checks++; if (tx_data !== '0) begin errors++; $display("[TB] FAIL reset_tx_data: got %0h expected 0", tx_data); end
    checks++; if (rx_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_ack: got %b expected 0", rx_ack); end
    checks++; if (recv_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_recv_valid: got %b expected 0", recv_valid); end
    checks++; if (sent_count !== '0 || recv_count !== '0) begin errors++; $display("[TB] FAIL reset_counts: got %0d/%0d expected 0/0", sent_count, recv_count); end
  endtask

  task automatic test_single_send();
    do_reset();
    send_valid = 1'b1; send_data = 16'h002A;
    #1;
    checks++; if (send_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready_idle: got %b expected 1", send_ready); end
    tick();
    send_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++; if (tx_req !== 1'b1 || tx_data !== 16'h002A) begin errors++; $display("[TB] FAIL single_req_hold: got req=%b data=%0h expected req=1 data=2a", tx_req, tx_data); end
      if (c == 0) tick();
    end
    tx_ack_r = 1'b1;
    tick();
    checks++; if (tx_req !== 1'b0 || sent_count !== 16'd1) begin errors++; $display("[TB] FAIL single_ack: got req=%b cnt=%0d expected req=0 cnt=1", tx_req, sent_count); end
    checks++; if (send_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_rtz_ready: got %b expected 0", send_ready); end
    tick();
    checks++; if (send_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_rtz_hold: got %b expected 0", send_ready); end
    tx_ack_r = 1'b0;
    tick();
    checks++; if (send_ready !== 1'b1 || tx_data !== 16'h002A) begin errors++; $display("[TB] FAIL single_done: got ready=%b data=%0h expected ready=1 data=2a", send_ready, tx_data); end
  endtask

  task automatic test_back_to_back();
    int ticks;
    do_reset();
    ack_comb = 1'b1;
    ticks = 0;
    for (int i = 1; i <= 5; i++) begin
      send_valid = 1'b1; send_data = SIZE'(i);
      tick(); ticks++;
      checks++; if (tx_req !== 1'b1 || tx_data !== SIZE'(i) || send_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_req: word %0d got req=%b data=%0h ready=%b", i, tx_req, tx_data, send_ready); end
      tick(); ticks++;
      checks++; if (tx_req !== 1'b0 || sent_count !== NI_CNT_W'(i) || send_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_rtz: word %0d got req=%b cnt=%0d ready=%b expected cnt=%0d", i, tx_req, sent_count, send_ready, i); end
      tick(); ticks++;
      checks++; if (send_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_idle: word %0d got ready=%b expected 1", i, send_ready); end
    end
    send_valid = 1'b0;
    ack_comb = 1'b0;
    checks++; if (sent_count !== 16'd5 || ticks != 15) begin errors++; $display("[TB] FAIL b2b_total: got cnt=%0d cycles=%0d expected 5/15", sent_count, ticks); end
  endtask

  task automatic test_recv_full();
    logic [SIZE-1:0] words [6];
    for (int i = 0; i < 6; i++) words[i] = SIZE'($urandom);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rx_data = words[i]; rx_req = 1'b1;
      tick();
      checks++; if (rx_ack !== 1'b1 || recv_count !== NI_CNT_W'(i + 1) || recv_valid !== 1'b1 || recv_data !== words[0]) begin errors++; $display("[TB] FAIL full_capture: word %0d got ack=%b cnt=%0d valid=%b head=%0h expected head=%0h", i, rx_ack, recv_count, recv_valid, recv_data, words[0]); end
      rx_req = 1'b0;
      tick();
      checks++; if (rx_ack !== 1'b0) begin errors++; $display("[TB] FAIL full_ack_drop: word %0d got %b expected 0", i, rx_ack); end
    end
    rx_data = words[4]; rx_req = 1'b1;
    repeat (3) begin
      tick();
      checks++; if (rx_ack !== 1'b0 || recv_count !== 16'd4) begin errors++; $display("[TB] FAIL full_hold: got ack=%b cnt=%0d expected 0/4", rx_ack, recv_count); end
    end
    recv_ready = 1'b1;
    tick();
    recv_ready = 1'b0;
    checks++; if (rx_ack !== 1'b0 || recv_count !== 16'd4 || recv_data !== words[1]) begin errors++; $display("[TB] FAIL full_pop_same_edge: got ack=%b cnt=%0d head=%0h expected 0/4/%0h", rx_ack, recv_count, recv_data, words[1]); end
    tick();
    checks++; if (rx_ack !== 1'b1 || recv_count !== 16'd5) begin errors++; $display("[TB] FAIL full_delayed_capture: got ack=%b cnt=%0d expected 1/5", rx_ack, recv_count); end
    rx_req = 1'b0;
    tick();
    rx_data = words[5]; rx_req = 1'b1;
    tick();
    checks++; if (rx_ack !== 1'b0 || recv_count !== 16'd5) begin errors++; $display("[TB] FAIL full_sixth_hold: got ack=%b cnt=%0d expected 0/5", rx_ack, recv_count); end
    recv_ready = 1'b1;
    tick();
    recv_ready = 1'b0;
    tick();
    checks++; if (rx_ack !== 1'b1 || recv_count !== 16'd6) begin errors++; $display("[TB] FAIL full_sixth_capture: got ack=%b cnt=%0d expected 1/6", rx_ack, recv_count); end
    rx_req = 1'b0;
    tick();
    for (int i = 2; i < 6; i++) begin
      checks++; if (recv_valid !== 1'b1 || recv_data !== words[i]) begin errors++; $display("[TB] FAIL full_drain_order: idx %0d got valid=%b data=%0h expected %0h", i, recv_valid, recv_data, words[i]); end
      recv_ready = 1'b1;
      tick();
      recv_ready = 1'b0;
    end
    checks++; if (recv_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_drain_empty: got %b expected 0", recv_valid); end
  endtask

  task automatic test_simul_half();
    logic [SIZE-1:0] words [3];
    for (int i = 0; i < 3; i++) words[i] = SIZE'($urandom);
    do_reset();
    for (int i = 0; i < 2; i++) begin
      rx_data = words[i]; rx_req = 1'b1;
      tick();
      rx_req = 1'b0;
      tick();
    end
    rx_data = words[2]; rx_req = 1'b1; recv_ready = 1'b1;
    tick();
    recv_ready = 1'b0; rx_req = 1'b0;
    checks++; if (rx_ack !== 1'b1 || recv_count !== 16'd3 || recv_data !== words[1]) begin errors++; $display("[TB] FAIL half_both: got ack=%b cnt=%0d head=%0h expected 1/3/%0h", rx_ack, recv_count, recv_data, words[1]); end
    tick();
    for (int i = 1; i < 3; i++) begin
      checks++; if (recv_valid !== 1'b1 || recv_data !== words[i]) begin errors++; $display("[TB] FAIL half_drain: idx %0d got valid=%b data=%0h expected %0h", i, recv_valid, recv_data, words[i]); end
      recv_ready = 1'b1;
      tick();
      recv_ready = 1'b0;
    end
    checks++; if (recv_valid !== 1'b0) begin errors++; $display("[TB] FAIL half_occupancy: got valid=%b expected 0", recv_valid); end
  endtask

  task automatic test_stale_ack();
    logic [SIZE-1:0] w1, w2;
    w1 = SIZE'($urandom); w2 = SIZE'($urandom);
    do_reset();
    send_valid = 1'b1; send_data = w1;
    tick();
    send_valid = 1'b0; tx_ack_r = 1'b1;
    tick(); tick();
    tx_ack_r = 1'b0;
    tick();
    checks++; if (send_ready !== 1'b1 || sent_count !== 16'd1) begin errors++; $display("[TB] FAIL stale_first_done: got ready=%b cnt=%0d expected 1/1", send_ready, sent_count); end
    tx_ack_r = 1'b1; send_valid = 1'b1; send_data = w2;
    #1;
    checks++; if (send_ready !== 1'b0) begin errors++; $display("[TB] FAIL stale_ready: got %b expected 0", send_ready); end
    repeat (3) begin
      tick();
      checks++; if (tx_req !== 1'b0 || tx_data !== w1 || sent_count !== 16'd1) begin errors++; $display("[TB] FAIL stale_no_accept: got req=%b data=%0h cnt=%0d expected 0/%0h/1", tx_req, tx_data, sent_count, w1); end
    end
    tx_ack_r = 1'b0;
    #1;
    checks++; if (send_ready !== 1'b1) begin errors++; $display("[TB] FAIL stale_ready_back: got %b expected 1", send_ready); end
    tick();
    send_valid = 1'b0;
    checks++; if (tx_req !== 1'b1 || tx_data !== w2) begin errors++; $display("[TB] FAIL stale_second_req: got req=%b data=%0h expected 1/%0h", tx_req, tx_data, w2); end
    tx_ack_r = 1'b1;
    tick();
    checks++; if (sent_count !== 16'd2) begin errors++; $display("[TB] FAIL stale_second_count: got %0d expected 2", sent_count); end
    tx_ack_r = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rx_data = SIZE'($urandom); rx_req = 1'b1;
      tick();
      if (i < 2) begin rx_req = 1'b0; tick(); end
    end
    send_valid = 1'b1; send_data = SIZE'($urandom);
    tick();
    send_valid = 1'b0;
    checks++; if (tx_req !== 1'b1 || rx_ack !== 1'b1 || recv_count !== 16'd3) begin errors++; $display("[TB] FAIL mid_setup: got req=%b ack=%b cnt=%0d expected 1/1/3", tx_req, rx_ack, recv_count); end
    reset = 1'b1; rx_req = 1'b0;
    tick();
    checks++; if (tx_req !== 1'b0 || rx_ack !== 1'b0 || recv_valid !== 1'b0 || tx_data !== '0) begin errors++; $display("[TB] FAIL mid_reset_outputs: got req=%b ack=%b valid=%b data=%0h expected all 0", tx_req, rx_ack, recv_valid, tx_data); end
    checks++; if (sent_count !== '0 || recv_count !== '0 || send_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_counts: got %0d/%0d ready=%b expected 0/0 ready=1", sent_count, recv_count, send_ready); end
    reset = 1'b0;
    send_valid = 1'b1; send_data = 16'h0055;
    tick();
    send_valid = 1'b0;
    checks++; if (tx_req !== 1'b1 || tx_data !== 16'h0055) begin errors++; $display("[TB] FAIL mid_next_req: got req=%b data=%0h expected 1/55", tx_req, tx_data); end
    tx_ack_r = 1'b1;
    tick();
    tx_ack_r = 1'b0;
    tick();
    checks++; if (sent_count !== 16'd1 || send_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_next_done: got cnt=%0d ready=%b expected 1/1", sent_count, send_ready); end
  endtask

  task automatic test_random();
    logic [SIZE-1:0] send_exp [$];
    logic [SIZE-1:0] recv_exp [$];
    do_reset();
    fork
      begin : tile_send
        @(posedge clk); #2;
        for (int n = 0; n < NWORDS; n++) begin
          int cyc;
          logic acc;
          send_data = SIZE'($urandom);
          send_valid = 1'b1;
          send_exp.push_back(send_data);
          acc = 1'b0; cyc = 0;
          while (!acc && cyc < 400) begin
            if (send_ready === 1'b1) acc = 1'b1;
            @(posedge clk); #2;
            cyc++;
          end
          if (!acc) begin errors++; $display("[TB] FAIL rand_send_timeout: word %0d not accepted", n); break; end
          if ($urandom_range(0, 3) == 0) begin
            send_valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #2; end
          end
        end
        send_valid = 1'b0;
      end
      begin : router_sink
        for (int n = 0; n < NWORDS; n++) begin
          int cyc;
          cyc = 0;
          while (tx_req !== 1'b1 && cyc < 400) begin tick(); cyc++; end
          if (cyc >= 400) begin errors++; $display("[TB] FAIL rand_tx_req_timeout: word %0d", n); break; end
          repeat ($urandom_range(0, 7)) tick();
          checks++;
          if (send_exp.size() == 0) begin errors++; $display("[TB] FAIL rand_tx_extra: word %0d data=%0h with empty scoreboard", n, tx_data); end
          else begin
            if (tx_data !== send_exp[0]) begin errors++; $display("[TB] FAIL rand_tx_data: word %0d got %0h expected %0h", n, tx_data, send_exp[0]); end
            void'(send_exp.pop_front());
          end
          tx_ack_r = 1'b1;
          cyc = 0;
          while (tx_req !== 1'b0 && cyc < 400) begin tick(); cyc++; end
          repeat ($urandom_range(0, 7)) tick();
          tx_ack_r = 1'b0;
          tick();
        end
      end
      begin : router_source
        for (int n = 0; n < NWORDS; n++) begin
          int cyc;
          repeat ($urandom_range(0, 7)) tick();
          rx_data = SIZE'($urandom);
          recv_exp.push_back(rx_data);
          rx_req = 1'b1;
          cyc = 0;
          while (rx_ack !== 1'b1 && cyc < 400) begin tick(); cyc++; end
          if (cyc >= 400) begin errors++; $display("[TB] FAIL rand_rx_ack_timeout: word %0d", n); break; end
          repeat ($urandom_range(0, 7)) tick();
          rx_req = 1'b0;
          cyc = 0;
          while (rx_ack !== 1'b0 && cyc < 400) begin tick(); cyc++; end
        end
        rx_req = 1'b0;
      end
      begin : tile_recv
        int got, cyc;
        got = 0; cyc = 0;
        @(posedge clk); #2;
        while (got < NWORDS && cyc < 60000) begin
          logic r;
          r = ($urandom_range(0, 1) == 1);
          recv_ready = r;
          if (r && recv_valid === 1'b1) begin
            checks++;
            if (recv_exp.size() == 0) begin errors++; $display("[TB] FAIL rand_recv_extra: data=%0h with empty scoreboard", recv_data); end
            else begin
              if (recv_data !== recv_exp[0]) begin errors++; $display("[TB] FAIL rand_recv_data: word %0d got %0h expected %0h", got, recv_data, recv_exp[0]); end
              void'(recv_exp.pop_front());
            end
            got++;
          end
          @(posedge clk); #2;
          cyc++;
        end
        recv_ready = 1'b0;
        if (got < NWORDS) begin errors++; $display("[TB] FAIL rand_recv_timeout: got %0d words expected %0d", got, NWORDS); end
      end
    join
    tick();
    checks++; if (sent_count !== NI_CNT_W'(NWORDS)) begin errors++; $display("[TB] FAIL rand_sent_count: got %0d expected %0d", sent_count, NWORDS); end
    checks++; if (recv_count !== NI_CNT_W'(NWORDS)) begin errors++; $display("[TB] FAIL rand_recv_count: got %0d expected %0d", recv_count, NWORDS); end
    checks++; if (send_exp.size() != 0 || recv_exp.size() != 0 || recv_valid !== 1'b0) begin errors++; $display("[TB] FAIL rand_leftover: send=%0d recv=%0d valid=%b expected 0/0/0", send_exp.size(), recv_exp.size(), recv_valid); end
  endtask

  initial begin
    $display("[TB] local_port_ni bench starting");
    test_reset();
    test_single_send();
    test_back_to_back();
    test_recv_full();
    test_simul_half();
    test_stale_ack();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
